// File: rtl/dds_pkg.sv
// Shared definitions for the output-side indicator logic.
//   state_e : FSM encoding (IDLE/ON/OFF). 2'd3 is illegal and recovers to IDLE.
//   T_*     : blink timing presets in clock cycles.
package dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam int unsigned T_TEST  = 300;
  localparam int unsigned T_100MS = 2_400_000;
  localparam int unsigned T_1S    = 24_000_000;

endpackage

// File: rtl/event_indicator_blink_timer.sv
// Blink phase timer.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : forces the count to 0 on the next edge (has priority over enable)
//   enable    : increments the count on the next edge
//   terminal  : phase length in cycles (>= 1)
//   done      : high while count == terminal-1, i.e. in the last cycle of the phase
module blink_timer
  import dds_pkg::*;
#(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The FSM clears the timer on every phase change, so the count never
  // runs past terminal-1 and cannot wrap.
  assign done = (cnt_q == (terminal - 1'b1));

endmodule

// File: rtl/event_indicator.sv
// LED event indicator.
// Turns single-cycle internal event strobes into visible blinks: each accepted
// event gives ON_TIME cycles of LED high followed by OFF_TIME cycles low.
// Events arriving during a blink are queued in a saturating counter and
// replayed back-to-back.
//   Fg_CLK   : system clock
//   RESET    : asynchronous active-high reset
//   IntEVT   : event strobe (each high cycle is one event)
//   ClrOvf   : synchronous clear of Overflow
//   ExtLED   : registered LED drive, high during the ON phase
//   Busy     : high whenever the FSM is not idle
//   Pending  : events accepted but not yet started
//   Overflow : sticky, set when an event is dropped at saturation
module event_indicator
  import dds_pkg::*;
#(
  parameter int unsigned ON_TIME  = T_TEST,
  parameter int unsigned OFF_TIME = T_TEST,
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned PEND_W   = 4
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic              IntEVT,
  input  logic              ClrOvf,
  output logic              ExtLED,
  output logic              Busy,
  output logic [PEND_W-1:0] Pending,
  output logic              Overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              led_q, led_d;

  logic              blink_start;
  logic              tmr_clear;
  logic              tmr_enable;
  logic              tmr_done;
  logic [CNT_W-1:0]  tmr_terminal;

  // Saturating pending update; a simultaneous accept and start cancel out.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur,
                                                  input logic inc,
                                                  input logic dec);
    logic [PEND_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != PEND_MAX)) begin
      nxt = cur + 1'b1;
    end else if (!inc && dec) begin
      nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

  assign tmr_terminal = (state_q == ST_ON) ? CNT_W'(ON_TIME) : CNT_W'(OFF_TIME);

  blink_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (Fg_CLK),
    .rst      (RESET),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .terminal (tmr_terminal),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    blink_start = 1'b0;
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (pend_q != '0) begin
          state_d     = ST_ON;
          blink_start = 1'b1;
        end
      end
      ST_ON: begin
        if (tmr_done) begin
          state_d   = ST_OFF;
          tmr_clear = 1'b1;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      ST_OFF: begin
        if (tmr_done) begin
          tmr_clear = 1'b1;
          // Chain straight into the next blink when work is queued.
          if (pend_q != '0) begin
            state_d     = ST_ON;
            blink_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_enable = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tmr_clear = 1'b1;
      end
    endcase
  end

  always_comb begin
    pend_d = pend_next(pend_q, IntEVT, blink_start);
    ovf_d  = ovf_q;
    // A drop in the same cycle as a clear keeps the flag set.
    if (IntEVT && !blink_start && (pend_q == PEND_MAX)) begin
      ovf_d = 1'b1;
    end else if (ClrOvf) begin
      ovf_d = 1'b0;
    end
    // Decoded from the next state so the LED register lines up with state_q.
    led_d = (state_d == ST_ON);
  end

  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
    end
  end

  assign ExtLED   = led_q;
  assign Busy     = (state_q != ST_IDLE);
  assign Pending  = pend_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_event_indicator.sv
module tb_event_indicator;

  logic       Fg_CLK = 1'b0;
  logic       RESET;
  logic       IntEVT;
  logic       ClrOvf;
  logic       ExtLED;
  logic       Busy;
  logic [1:0] Pending;
  logic       Overflow;

  int nvec = 0;
  int nerr = 0;

  event_indicator #(
    .ON_TIME  (3),
    .OFF_TIME (2),
    .CNT_W    (4),
    .PEND_W   (2)
  ) dut (
    .Fg_CLK   (Fg_CLK),
    .RESET    (RESET),
    .IntEVT   (IntEVT),
    .ClrOvf   (ClrOvf),
    .ExtLED   (ExtLED),
    .Busy     (Busy),
    .Pending  (Pending),
    .Overflow (Overflow)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  task automatic do_reset();
    RESET  = 1'b1;
    IntEVT = 1'b0;
    ClrOvf = 1'b0;
    repeat (2) @(posedge Fg_CLK);
    #1 RESET = 1'b0;
  endtask

  // One cycle: inputs applied just after the rising edge, outputs observed
  // at the falling edge. Cycle 0 is the first cycle after reset release.
  task automatic cyc(input logic evt, input logic clr);
    @(posedge Fg_CLK);
    #1;
    IntEVT = evt;
    ClrOvf = clr;
    @(negedge Fg_CLK);
  endtask

  task automatic test_reset();
    RESET  = 1'b1;
    IntEVT = 1'b1;
    ClrOvf = 1'b0;
    repeat (2) @(posedge Fg_CLK);
    #2;
    nvec++;
    if ({ExtLED, Busy, Pending, Overflow} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_hold: got led=%b busy=%b pend=%0d ovf=%b, expected all 0",
               ExtLED, Busy, Pending, Overflow);
    end
    IntEVT = 1'b0;
    #1 RESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 1'b0);
      nvec++;
      if ({ExtLED, Busy, Pending, Overflow} !== 5'b0) begin
        nerr++;
        $display("FAIL reset_idle cycle %0d: got led=%b busy=%b pend=%0d ovf=%b, expected all 0",
                 c, ExtLED, Busy, Pending, Overflow);
      end
    end
  endtask

  task automatic test_single_blink();
    logic [63:0] led_m;
    logic [63:0] busy_m;
    logic [1:0]  exp_p;
    led_m  = 64'h0000_7000;   // cycles 12-14
    busy_m = 64'h0001_F000;   // cycles 12-16
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(c == 10, 1'b0);
      exp_p = (c == 11) ? 2'd1 : 2'd0;
      nvec++;
      if (ExtLED !== led_m[c] || Busy !== busy_m[c] || Pending !== exp_p || Overflow !== 1'b0) begin
        nerr++;
        $display("FAIL single_blink cycle %0d: got led=%b busy=%b pend=%0d ovf=%b, expected led=%b busy=%b pend=%0d ovf=0",
                 c, ExtLED, Busy, Pending, Overflow, led_m[c], busy_m[c], exp_p);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] led_m;
    logic [63:0] busy_m;
    logic [1:0]  exp_p;
    led_m  = 64'h000E_7000;   // cycles 12-14 and 17-19
    busy_m = 64'h003F_F000;   // cycles 12-21
    do_reset();
    for (int c = 0; c < 25; c++) begin
      cyc(c == 10 || c == 13, 1'b0);
      exp_p = (c == 11 || (c >= 14 && c <= 16)) ? 2'd1 : 2'd0;
      nvec++;
      if (ExtLED !== led_m[c] || Busy !== busy_m[c] || Pending !== exp_p) begin
        nerr++;
        $display("FAIL back_to_back cycle %0d: got led=%b busy=%b pend=%0d, expected led=%b busy=%b pend=%0d",
                 c, ExtLED, Busy, Pending, led_m[c], busy_m[c], exp_p);
      end
    end
  endtask

  task automatic test_saturation();
    logic [63:0] led_m;
    logic [63:0] busy_m;
    logic [1:0]  exp_p;
    logic        exp_o;
    led_m  = 64'h0000_0000_39CE_7000;  // four blinks: 12-14, 17-19, 22-24, 27-29
    busy_m = 64'h0000_0000_FFFF_F000;  // cycles 12-31
    do_reset();
    for (int c = 0; c < 36; c++) begin
      cyc(c >= 10 && c <= 15, 1'b0);
      if (c == 11 || c == 12)      exp_p = 2'd1;
      else if (c == 13)            exp_p = 2'd2;
      else if (c >= 14 && c <= 16) exp_p = 2'd3;
      else if (c >= 17 && c <= 21) exp_p = 2'd2;
      else if (c >= 22 && c <= 26) exp_p = 2'd1;
      else                         exp_p = 2'd0;
      exp_o = (c >= 15);
      nvec++;
      if (ExtLED !== led_m[c] || Busy !== busy_m[c] || Pending !== exp_p || Overflow !== exp_o) begin
        nerr++;
        $display("FAIL saturation cycle %0d: got led=%b busy=%b pend=%0d ovf=%b, expected led=%b busy=%b pend=%0d ovf=%b",
                 c, ExtLED, Busy, Pending, Overflow, led_m[c], busy_m[c], exp_p, exp_o);
      end
    end
    cyc(1'b0, 1'b1);
    nvec++;
    if (Overflow !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_before_clear: got %b expected 1", Overflow);
    end
    cyc(1'b0, 1'b0);
    nvec++;
    if (Overflow !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_cleared: got %b expected 0", Overflow);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int c = 0; c < 12; c++) cyc(c == 10 || c == 11, 1'b0);
    // Cycle 11: blink start coincides with a new event.
    cyc(1'b1, 1'b0);  // cycle 12
    nvec++;
    if (Pending !== 2'd1 || ExtLED !== 1'b1) begin
      nerr++;
      $display("FAIL inc_dec_same: got pend=%0d led=%b expected pend=1 led=1", Pending, ExtLED);
    end
    cyc(1'b1, 1'b0);  // cycle 13
    cyc(1'b1, 1'b1);  // cycle 14: pending full, drop and clear together
    nvec++;
    if (Pending !== 2'd3 || Overflow !== 1'b0) begin
      nerr++;
      $display("FAIL sat_reached: got pend=%0d ovf=%b expected pend=3 ovf=0", Pending, Overflow);
    end
    cyc(1'b0, 1'b0);  // cycle 15
    nvec++;
    if (Overflow !== 1'b1 || Pending !== 2'd3) begin
      nerr++;
      $display("FAIL set_beats_clear: got ovf=%b pend=%0d expected ovf=1 pend=3", Overflow, Pending);
    end
  endtask

  task automatic test_reset_mid_blink();
    do_reset();
    for (int c = 0; c < 13; c++) cyc(c == 10 || c == 12, 1'b0);
    @(posedge Fg_CLK);  // start of cycle 13
    #1 IntEVT = 1'b0;
    nvec++;
    if (ExtLED !== 1'b1 || Busy !== 1'b1 || Pending !== 2'd1) begin
      nerr++;
      $display("FAIL pre_reset_blink: got led=%b busy=%b pend=%0d expected led=1 busy=1 pend=1",
               ExtLED, Busy, Pending);
    end
    #1 RESET = 1'b1;
    #1;
    nvec++;
    if ({ExtLED, Busy, Pending, Overflow} !== 5'b0) begin
      nerr++;
      $display("FAIL async_reset: got led=%b busy=%b pend=%0d ovf=%b expected all 0",
               ExtLED, Busy, Pending, Overflow);
    end
    repeat (2) @(posedge Fg_CLK);
    #1 RESET = 1'b0;
    for (int c = 0; c < 15; c++) begin
      cyc(1'b0, 1'b0);
      nvec++;
      if (ExtLED !== 1'b0 || Busy !== 1'b0 || Pending !== 2'd0) begin
        nerr++;
        $display("FAIL post_reset_quiet cycle %0d: got led=%b busy=%b pend=%0d expected 0 0 0",
                 c, ExtLED, Busy, Pending);
      end
    end
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    nvec++;
    if (Pending !== 2'd1 || ExtLED !== 1'b0) begin
      nerr++;
      $display("FAIL post_reset_accept: got pend=%0d led=%b expected pend=1 led=0", Pending, ExtLED);
    end
    cyc(1'b0, 1'b0);
    nvec++;
    if (ExtLED !== 1'b1 || Busy !== 1'b1) begin
      nerr++;
      $display("FAIL post_reset_blink: got led=%b busy=%b expected led=1 busy=1", ExtLED, Busy);
    end
  endtask

  task automatic test_late_event();
    logic [63:0] led_m;
    logic [63:0] busy_m;
    led_m  = 64'h001C_7000;   // cycles 12-14 and 18-20
    busy_m = 64'h007D_F000;   // cycles 12-16 and 18-22, idle at 17
    do_reset();
    for (int c = 0; c < 26; c++) begin
      cyc(c == 10 || c == 16, 1'b0);
      nvec++;
      if (ExtLED !== led_m[c] || Busy !== busy_m[c]) begin
        nerr++;
        $display("FAIL late_event cycle %0d: got led=%b busy=%b expected led=%b busy=%b",
                 c, ExtLED, Busy, led_m[c], busy_m[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_blink();
    test_back_to_back();
    test_saturation();
    test_simultaneous();
    test_reset_mid_blink();
    test_late_event();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
